mac_dot: RTL and testbench
==========================

Name: mac_dot

Overview:
- N-lane signed dot-product MAC for the systolic-array PE.
- Each beat multiplies N activation/weight pairs, reduces them through a registered adder tree and accumulates into a WY-bit register.
- The final sum is requantized (round, shift, saturate) to WO bits with its own valid.
- Generalises the single-lane MAC with lane count, end-of-sum marking, output valid and requantization.

Parameters:
- N, 4, lanes per beat (≥1); D = $clog2(N) adder-tree levels.
- WX, 4, signed activation width per lane.
- WK, 8, signed weight width per lane.
- WY, 16, accumulator / raw output width.
- WO, 8, requantized output width (WO ≤ WY).
- LM, 1, multiplier pipeline stages (≥1).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  global clock-enable; 0 freezes every register.
- m_valid  in  1  beat valid.
- m_first  in  1  beat starts a new sum.
- m_last  in  1  beat ends the sum.
- x  in  N*WX  lane activations, lane i at [i*WX +: WX].
- k  in  N*WK  lane weights, lane i at [i*WK +: WK].
- shift  in  $clog2(WY)  requant right-shift; quasi-static, sampled at the requant stage.
- y  out  WY  accumulator value.
- y_valid  out  1  y holds a completed sum.
- q  out  WO  requantized result.
- q_valid  out  1  q is valid.
- q_ovf  out  1  q was saturated.

Behaviour:
- Reset: all pipeline, sideband and output registers clear asynchronously. y=0, y_valid=0, q=0, q_valid=0, q_ovf=0. A reset mid-sum discards it; later beats without m_first accumulate from 0.
- Register advance: every register advances only on clk edges with en=1. With en=0 all state, including y_valid and q_valid, holds unchanged.
- Multiply: per-lane signed product, WM = WX+WK bits, registered through LM stages.
- Adder tree: D registered levels, sign-extended sum width WS = WM+D. For N=1 there are no tree stages.
- Sideband: m_valid, m_first and m_last travel alongside the data through the multiply and tree stages (LM+D stages).
- Accumulate, on an aligned beat with valid=1:
  - acc <= WY'(sum) + (first ? 0 : acc), in two's complement.
  - The accumulator wraps mod 2^WY, with no saturation.
  - Beats with valid=0 are bubbles: acc holds, first/last are ignored.
- y_valid: registered with acc, equals aligned valid & last. It is a 1-enabled-cycle pulse.
  - first & last on the same beat gives a single-beat sum.
  - last then first on consecutive beats gives back-to-back sums, no bubble needed.
- Latency: input beat to y update = LM+D+1 enabled cycles. Defaults: 4.
- Requant stage (one register, updates when en=1 and y_valid=1):
  - r = (y + (shift ? 1<<(shift-1) : 0)) >>> shift, computed in WY+1 bits so the rounding add cannot overflow.
  - q = r clamped to [-2^(WO-1), 2^(WO-1)-1].
  - q_ovf=1 iff clamping occurred.
  - q_valid = registered y_valid.
  - q/q_ovf hold between results.
- Throughput: one beat per enabled cycle; no backpressure.

Decomposition:
- Package mac_pkg:
  - Width localparams derived from parameters (WM, D, WS).
  - Function round_shift_sat(value, shift) returning {ovf, q}, shared with future requant blocks.
- Sub-module adder_tree:
  - Parameters N, W.
  - Registered, en-gated, async-reset.
  - Carries a sideband bus of width WSB through D stages.
  - Output width W+D.

Test Plan (defaults N=4, WX=4, WK=8, WY=16, WO=8, LM=1):
- Single-beat sum: x all lanes 1, k={4,3,2,1}, first=last=valid=1, shift=0 -> y=10 and y_valid pulse 4 cycles later; q=10, q_valid=1 one cycle after.
- Wrap and saturate: x=-8, k=-128 in all lanes, 8 beats (first on beat 0, last on beat 7) -> y=-32768 (32768 wraps); q=-128, q_ovf=1.
- Rounding: sum 100 with shift=3 -> q=13. Sum -100 with shift=3 -> q=-12. Sum 0x7FFF with shift=0 -> q=127, q_ovf=1.
- Stall and bubbles: a 3-beat sum with en=0 for 3 cycles mid-stream and valid=0 bubbles between beats -> same y as the unstalled run; y_valid delayed by the 3 stall cycles and held during stalls.
- Back-to-back sums: beats {first,last}, {first}, {last}, each with x=1 lanes, k={1,1,1,1} -> y=4 then y=8; y_valid pulses on two consecutive-result cycles, with no carry-over between sums.
- Async reset mid-sum: assert rstn low between edges -> y, y_valid, q, q_valid, q_ovf all 0 immediately. After release, a beat without first (lanes x=1, k=1) and with last -> y=4.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths, sideband type and requantization helper for the dot-product MAC family.
// Pure declarations; no state and no backpressure.
package mac_pkg;

    localparam int N_DEF  = 4;
    localparam int WX_DEF = 4;
    localparam int WK_DEF = 8;
    localparam int WY_DEF = 16;
    localparam int WO_DEF = 8;
    localparam int LM_DEF = 1;

    // Requant arithmetic is carried at this width so any WY up to 63 rounds without overflow.
    localparam int RQ_W = 64;

    function automatic int tree_depth(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    function automatic int prod_width(input int wx, input int wk);
        return wx + wk;
    endfunction

    function automatic int sum_width(input int wx, input int wk, input int n);
        return prod_width(wx, wk) + tree_depth(n);
    endfunction

    localparam int WM_DEF = prod_width(WX_DEF, WK_DEF);
    localparam int D_DEF  = tree_depth(N_DEF);
    localparam int WS_DEF = sum_width(WX_DEF, WK_DEF, N_DEF);

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } sb_t;

    // Returns {ovf, result}; result is round-half-up, arithmetic shift, clamped to wo bits.
    function automatic logic [RQ_W:0] round_shift_sat(
        input logic signed [RQ_W-1:0] value,
        input logic        [5:0]      shift,
        input int unsigned            wo
    );
        logic signed [RQ_W-1:0] rnd;
        logic signed [RQ_W-1:0] r;
        logic signed [RQ_W-1:0] hi;
        logic signed [RQ_W-1:0] lo;
        logic                   ovf;
        rnd = (shift == 6'd0) ? '0 : (RQ_W'(1) << (shift - 6'd1));
        r   = (value + rnd) >>> shift;
        hi  = (RQ_W'(1) << (wo - 1)) - 1;
        lo  = -hi - 1;
        ovf = 1'b0;
        if (r > hi) begin
            r   = hi;
            ovf = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            ovf = 1'b1;
        end
        return {ovf, r};
    endfunction

endpackage

// File: rtl/adder_tree.sv
// Registered binary reduction of N signed W-bit lanes to one W+D bit sum, sideband in lockstep.
// Latency D enabled cycles (zero for N=1); en=0 freezes all stages, no backpressure.
module adder_tree
    import mac_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 12,
    parameter int WSB = 3,
    localparam int D  = tree_depth(N)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [N*W-1:0]        in_dat,
    input  logic [WSB-1:0]        sb_in,
    output logic signed [W+D-1:0] sum_dat,
    output logic [WSB-1:0]        sb_out
);

    localparam int P  = 1 << D;
    localparam int WT = W + D;

    if (D == 0) begin : g_pass
        assign sum_dat = in_dat;
        assign sb_out  = sb_in;
    end else begin : g_tree
        logic [P*W-1:0]         in_pad;
        logic signed [WT-1:0]   lane   [P];
        logic signed [WT-1:0]   node_d [D][P/2];
        logic signed [WT-1:0]   node_q [D][P/2];
        logic [WSB-1:0]         sb_d   [D];
        logic [WSB-1:0]         sb_q   [D];

        // Missing lanes up to the next power of two contribute zero.
        assign in_pad = (P*W)'(in_dat);

        always_comb begin
            for (int i = 0; i < P; i++) begin
                lane[i] = {{D{in_pad[i*W+W-1]}}, in_pad[i*W +: W]};
            end
            for (int l = 0; l < D; l++) begin
                for (int j = 0; j < P/2; j++) begin
                    node_d[l][j] = '0;
                end
            end
            for (int j = 0; j < P/2; j++) begin
                node_d[0][j] = lane[2*j] + lane[2*j+1];
            end
            for (int l = 1; l < D; l++) begin
                for (int j = 0; j < (P >> (l+1)); j++) begin
                    node_d[l][j] = node_q[l-1][2*j] + node_q[l-1][2*j+1];
                end
            end
            sb_d[0] = sb_in;
            for (int l = 1; l < D; l++) begin
                sb_d[l] = sb_q[l-1];
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int l = 0; l < D; l++) begin
                    sb_q[l] <= '0;
                    for (int j = 0; j < P/2; j++) begin
                        node_q[l][j] <= '0;
                    end
                end
            end else if (en) begin
                for (int l = 0; l < D; l++) begin
                    sb_q[l] <= sb_d[l];
                    for (int j = 0; j < P/2; j++) begin
                        node_q[l][j] <= node_d[l][j];
                    end
                end
            end
        end

        assign sum_dat = node_q[D-1][0];
        assign sb_out  = sb_q[D-1];
    end

endmodule

// File: rtl/mac_dot.sv
// N-lane signed dot-product MAC: multiply, adder tree, wrapping accumulate, round/shift/saturate.
// Beat to y is LM+D+1 enabled cycles, q one more; en=0 freezes everything, no backpressure.
module mac_dot
    import mac_pkg::*;
#(
    parameter int N  = 4,
    parameter int WX = 4,
    parameter int WK = 8,
    parameter int WY = 16,
    parameter int WO = 8,
    parameter int LM = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  m_valid,
    input  logic                  m_first,
    input  logic                  m_last,
    input  logic [N*WX-1:0]       x,
    input  logic [N*WK-1:0]       k,
    input  logic [$clog2(WY)-1:0] shift,
    output logic [WY-1:0]         y,
    output logic                  y_valid,
    output logic [WO-1:0]         q,
    output logic                  q_valid,
    output logic                  q_ovf
);

    localparam int WM = prod_width(WX, WK);
    localparam int D  = tree_depth(N);
    localparam int WS = WM + D;

    logic [N*WM-1:0]      prod;
    logic [N*WM-1:0]      mul_d    [LM];
    logic [N*WM-1:0]      mul_q    [LM];
    sb_t                  mul_sb_d [LM];
    sb_t                  mul_sb_q [LM];
    logic signed [WS-1:0] tree_sum;
    sb_t                  tree_sb;
    logic [WY-1:0]        acc_d, acc_q;
    logic                 y_valid_d, y_valid_q;
    logic [RQ_W:0]        rq;
    logic [WO-1:0]        q_d, q_q;
    logic                 q_ovf_d, q_ovf_q;
    logic                 q_valid_d, q_valid_q;

    // Operands are sign-extended to the product width so the low WM bits are the exact product.
    always_comb begin
        logic [WM-1:0] xe;
        logic [WM-1:0] ke;
        xe   = '0;
        ke   = '0;
        prod = '0;
        for (int i = 0; i < N; i++) begin
            xe = {{WK{x[i*WX+WX-1]}}, x[i*WX +: WX]};
            ke = {{WX{k[i*WK+WK-1]}}, k[i*WK +: WK]};
            prod[i*WM +: WM] = xe * ke;
        end
        mul_d[0]    = prod;
        mul_sb_d[0] = {m_valid, m_first, m_last};
        for (int s = 1; s < LM; s++) begin
            mul_d[s]    = mul_q[s-1];
            mul_sb_d[s] = mul_sb_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < LM; s++) begin
                mul_q[s]    <= '0;
                mul_sb_q[s] <= '0;
            end
        end else if (en) begin
            for (int s = 0; s < LM; s++) begin
                mul_q[s]    <= mul_d[s];
                mul_sb_q[s] <= mul_sb_d[s];
            end
        end
    end

    adder_tree #(
        .N   (N),
        .W   (WM),
        .WSB ($bits(sb_t))
    ) u_tree (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .in_dat  (mul_q[LM-1]),
        .sb_in   (mul_sb_q[LM-1]),
        .sum_dat (tree_sum),
        .sb_out  (tree_sb)
    );

    // Bubbles leave the accumulator untouched; first/last only matter on valid beats.
    always_comb begin
        acc_d     = acc_q;
        y_valid_d = 1'b0;
        if (tree_sb.vld) begin
            acc_d     = WY'(tree_sum) + (tree_sb.first ? '0 : acc_q);
            y_valid_d = tree_sb.last;
        end
    end

    always_comb begin
        rq        = round_shift_sat({{(RQ_W-WY){acc_q[WY-1]}}, acc_q}, 6'(shift), WO);
        q_d       = q_q;
        q_ovf_d   = q_ovf_q;
        q_valid_d = y_valid_q;
        if (y_valid_q) begin
            q_d     = rq[WO-1:0];
            q_ovf_d = rq[RQ_W];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q     <= '0;
            y_valid_q <= 1'b0;
            q_q       <= '0;
            q_ovf_q   <= 1'b0;
            q_valid_q <= 1'b0;
        end else if (en) begin
            acc_q     <= acc_d;
            y_valid_q <= y_valid_d;
            q_q       <= q_d;
            q_ovf_q   <= q_ovf_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign y       = acc_q;
    assign y_valid = y_valid_q;
    assign q       = q_q;
    assign q_ovf   = q_ovf_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_mac_dot.sv
// Randomized and directed stimulus against a plain-arithmetic dot-product model; scoreboard queues.
module tb_mac_dot;

    localparam int N  = 4;
    localparam int WX = 4;
    localparam int WK = 8;
    localparam int WY = 16;
    localparam int WO = 8;

    logic            clk     = 1'b0;
    logic            rstn    = 1'b0;
    logic            en      = 1'b0;
    logic            m_valid = 1'b0;
    logic            m_first = 1'b0;
    logic            m_last  = 1'b0;
    logic [N*WX-1:0] x       = '0;
    logic [N*WK-1:0] k       = '0;
    logic [3:0]      shift   = '0;
    logic [WY-1:0]   y;
    logic            y_valid;
    logic [WO-1:0]   q;
    logic            q_valid;
    logic            q_ovf;

    int tests = 0;
    int fails = 0;

    shortint acc_m = 0;
    int      y_exp[$];
    int      q_exp[$];
    bit      ovf_exp[$];

    always #5 clk = ~clk;

    mac_dot dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .m_valid (m_valid),
        .m_first (m_first),
        .m_last  (m_last),
        .x       (x),
        .k       (k),
        .shift   (shift),
        .y       (y),
        .y_valid (y_valid),
        .q       (q),
        .q_valid (q_valid),
        .q_ovf   (q_ovf)
    );

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int beat_sum(input logic [N*WX-1:0] xv, input logic [N*WK-1:0] kv);
        int s;
        int xi;
        int ki;
        s = 0;
        for (int i = 0; i < N; i++) begin
            xi = $signed(xv[i*WX +: WX]);
            ki = $signed(kv[i*WK +: WK]);
            s += xi * ki;
        end
        return s;
    endfunction

    // Round half up, floor-divide by 2^sh, clamp to the signed WO-bit range.
    function automatic int ref_q(input int yv, input int sh, output bit ovf);
        longint v;
        longint hi;
        longint lo;
        v   = yv;
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v   = v >>> sh;
        hi  = (longint'(1) << (WO - 1)) - 1;
        lo  = -(longint'(1) << (WO - 1));
        ovf = 1'b0;
        if (v > hi) begin v = hi; ovf = 1'b1; end
        if (v < lo) begin v = lo; ovf = 1'b1; end
        return int'(v);
    endfunction

    function automatic logic [N*WX-1:0] xl(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [N*WK-1:0] kl(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Reference model: consumes every enabled valid beat, predicts each finished sum.
    always @(posedge clk or negedge rstn) begin
        bit ov;
        int qv;
        if (!rstn) begin
            acc_m = 0;
            y_exp.delete();
            q_exp.delete();
            ovf_exp.delete();
        end else if (en && m_valid) begin
            acc_m = shortint'(m_first ? beat_sum(x, k) : int'(acc_m) + beat_sum(x, k));
            if (m_last) begin
                qv = ref_q(int'(acc_m), int'(shift), ov);
                y_exp.push_back(int'(acc_m));
                q_exp.push_back(qv);
                ovf_exp.push_back(ov);
            end
        end
    end

    bit en_edge   = 1'b0;
    bit yv_prev   = 1'b0;
    int q_last    = 0;
    bit ovf_last  = 1'b0;

    always @(posedge clk) en_edge = en;

    always @(negedge clk) begin
        if (!rstn) begin
            yv_prev  = 1'b0;
            q_last   = 0;
            ovf_last = 1'b0;
        end else begin
            if (!en_edge) begin
                chk("y_valid_hold_stall", y_valid, yv_prev);
            end else begin
                if (y_valid) begin
                    if (y_exp.size() == 0) chk("y_unexpected", 1, 0);
                    else chk("y", $signed(y), y_exp.pop_front());
                end
                if (q_valid) begin
                    if (q_exp.size() == 0) begin
                        chk("q_unexpected", 1, 0);
                    end else begin
                        q_last   = q_exp.pop_front();
                        ovf_last = ovf_exp.pop_front();
                        chk("q", $signed(q), q_last);
                        chk("q_ovf", q_ovf, ovf_last);
                    end
                end else begin
                    chk("q_hold", $signed(q), q_last);
                    chk("q_ovf_hold", q_ovf, ovf_last);
                end
            end
            yv_prev = y_valid;
        end
    end

    task automatic beat(input bit v, input bit f, input bit l,
                        input logic [N*WX-1:0] xv, input logic [N*WK-1:0] kv);
        m_valid = v;
        m_first = f;
        m_last  = l;
        x       = xv;
        k       = kv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((y_exp.size() != 0 || q_exp.size() != 0) && c < 40) begin
            idle(1);
            c++;
        end
        chk("drain_pending", y_exp.size() + q_exp.size(), 0);
        idle(2);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_y_valid"}, y_valid, 0);
        chk({tag, "_q"}, q, 0);
        chk({tag, "_q_valid"}, q_valid, 0);
        chk({tag, "_q_ovf"}, q_ovf, 0);
    endtask

    initial begin
        logic [N*WX-1:0] ones_x;
        logic [N*WK-1:0] ones_k;
        ones_x = xl(1, 1, 1, 1);
        ones_k = kl(1, 1, 1, 1);

        en = 1'b1;
        #12;
        chk_zero_outputs("reset");
        #5 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single-beat sum with explicit latency: y_valid first seen after the 4th enabled edge.
        shift = 4'd0;
        beat(1'b1, 1'b1, 1'b1, ones_x, kl(1, 2, 3, 4));
        m_valid = 1'b0; m_first = 1'b0; m_last = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("latency_y_valid", y_valid, (c == 4) ? 1 : 0);
            if (c == 4) chk("single_y", $signed(y), 10);
            @(posedge clk);
            #1;
        end
        drain();

        // Wraps to -32768 and saturates.
        for (int b = 0; b < 8; b++)
            beat(1'b1, b == 0, b == 7, xl(-8, -8, -8, -8), kl(-128, -128, -128, -128));
        drain();

        shift = 4'd3;
        beat(1'b1, 1'b1, 1'b1, xl(5, 0, 0, 0), kl(20, 0, 0, 0));
        beat(1'b1, 1'b1, 1'b1, xl(-5, 0, 0, 0), kl(20, 0, 0, 0));
        drain();

        // 7*4096 + 3072 + 1023 = 32767.
        shift = 4'd0;
        for (int b = 0; b < 7; b++)
            beat(1'b1, b == 0, 1'b0, xl(-8, -8, -8, -8), kl(-128, -128, -128, -128));
        beat(1'b1, 1'b0, 1'b0, xl(-8, -8, -8, 0), kl(-128, -128, -128, 0));
        beat(1'b1, 1'b0, 1'b1, xl(7, 2, 0, 0), kl(127, 67, 0, 0));
        drain();

        // Stall with junk inputs mid-sum, bubbles, then a stall while y_valid is high.
        beat(1'b1, 1'b1, 1'b0, xl(3, -2, 1, 7), kl(9, -4, 100, -1));
        idle(1);
        beat(1'b1, 1'b0, 1'b0, xl(-1, 4, 2, 2), kl(50, 8, -7, 3));
        en = 1'b0;
        for (int s = 0; s < 3; s++)
            beat(1'b1, 1'b1, 1'b1, 16'($urandom), 32'($urandom));
        en = 1'b1;
        idle(2);
        beat(1'b1, 1'b0, 1'b1, xl(6, 6, -6, 1), kl(-30, 11, 12, 127));
        idle(3);
        en = 1'b0;
        idle(3);
        en = 1'b1;
        drain();

        // Back-to-back sums: 4 then 8.
        beat(1'b1, 1'b1, 1'b1, ones_x, ones_k);
        beat(1'b1, 1'b1, 1'b0, ones_x, ones_k);
        beat(1'b1, 1'b0, 1'b1, ones_x, ones_k);
        drain();

        shift = 4'($urandom_range(0, 15));
        for (int c = 0; c < 300; c++) begin
            en = ($urandom_range(0, 9) != 0);
            beat(1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 16'($urandom), 32'($urandom));
        end
        en = 1'b1;
        drain();

        // Async reset between edges in the middle of a sum.
        shift = 4'd0;
        beat(1'b1, 1'b1, 1'b1, xl(7, 7, 7, 7), kl(100, 100, 100, 100));
        beat(1'b1, 1'b1, 1'b0, ones_x, ones_k);
        beat(1'b1, 1'b0, 1'b0, ones_x, ones_k);
        idle(2);
        #2 rstn = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        @(negedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        beat(1'b1, 1'b0, 1'b1, ones_x, ones_k);
        m_valid = 1'b0; m_first = 1'b0; m_last = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 4) begin
                chk("post_reset_y_valid", y_valid, 1);
                chk("post_reset_y", $signed(y), 4);
            end
            @(posedge clk);
            #1;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
